// File: rtl/serial_bit_word_assembler.sv
// Serial-to-parallel word assembler: accepts one bit per beat (LSB first) into a
// WIDTH-bit register, then offers the finished word on a valid/ready handshake.
module serial_bit_word_assembler #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     sin_valid,
    input  logic                     sin_data,
    output logic                     sin_ready,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_data,
    output logic [$clog2(WIDTH)-1:0] bit_idx,
    output logic [CNT_W-1:0]         word_cnt
);

    localparam int unsigned IDX_W = $clog2(WIDTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

    typedef enum logic {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } state_e;

    state_e             state_q,     state_d;
    logic [IDX_W-1:0]   bit_idx_q,   bit_idx_d;
    logic [WIDTH-1:0]   out_data_q,  out_data_d;
    logic               out_valid_q, out_valid_d;
    logic [CNT_W-1:0]   word_cnt_q,  word_cnt_d;

    // Next-state logic: bit capture while collecting, handshake while holding.
    always_comb begin
        state_d     = state_q;
        bit_idx_d   = bit_idx_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        word_cnt_d  = word_cnt_q;

        case (state_q)
            COLLECT: begin
                if (flush) begin
                    bit_idx_d  = '0;
                    out_data_d = '0;
                end else if (sin_valid) begin
                    out_data_d[bit_idx_q] = sin_data;
                    if (bit_idx_q == LAST_IDX) begin
                        bit_idx_d   = '0;
                        out_valid_d = 1'b1;
                        state_d     = HOLD;
                    end else begin
                        bit_idx_d = bit_idx_q + IDX_W'(1);
                    end
                end
            end
            HOLD: begin
                // A completed word is never discarded; flush and sin_valid are ignored here.
                if (out_valid_q && out_ready) begin
                    out_valid_d = 1'b0;
                    out_data_d  = '0;
                    word_cnt_d  = word_cnt_q + CNT_W'(1);
                    state_d     = COLLECT;
                end
            end
            default: begin
                state_d = COLLECT;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= COLLECT;
            bit_idx_q   <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            word_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            bit_idx_q   <= bit_idx_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            word_cnt_q  <= word_cnt_d;
        end
    end

    assign sin_ready = (state_q == COLLECT);
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign bit_idx   = bit_idx_q;
    assign word_cnt  = word_cnt_q;

endmodule

// File: tb/tb_serial_bit_word_assembler.sv
// Bench for serial_bit_word_assembler: directed vector table, hand sequences for
// flush/bubbles/reset/counter wrap, then random traffic against a queue-based model.
module tb_serial_bit_word_assembler;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned CNT_W = 2;

    logic             clk = 1'b0;
    logic             rst, flush, sin_valid, sin_data, out_ready;
    logic             sin_ready, out_valid;
    logic [WIDTH-1:0] out_data;
    logic [2:0]       bit_idx;
    logic [CNT_W-1:0] word_cnt;

    int n_checks = 0;
    int n_errors = 0;

    serial_bit_word_assembler #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .sin_valid (sin_valid),
        .sin_data  (sin_data),
        .sin_ready (sin_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .bit_idx   (bit_idx),
        .word_cnt  (word_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: accepted bits kept in a queue, delivered words as an int.
    bit mq[$];
    int mcnt = 0;

    function automatic logic [WIDTH-1:0] model_word();
        logic [WIDTH-1:0] w = '0;
        foreach (mq[i]) w = w | (WIDTH'(mq[i]) << i);
        return w;
    endfunction

    function automatic bit model_holding();
        return mq.size() == WIDTH;
    endfunction

    task automatic model_edge();
        if (rst) begin
            mq.delete();
            mcnt = 0;
        end else if (model_holding()) begin
            if (out_ready) begin
                mq.delete();
                mcnt = (mcnt + 1) % (1 << CNT_W);
            end
        end else if (flush) begin
            mq.delete();
        end else if (sin_valid) begin
            mq.push_back(sin_data);
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    task automatic chk_model();
        chk("model_out_valid", 32'(out_valid), 32'(model_holding()));
        chk("model_out_data",  32'(out_data),  32'(model_word()));
        chk("model_bit_idx",   32'(bit_idx),   32'(mq.size() % WIDTH));
        chk("model_sin_ready", 32'(sin_ready), 32'(!model_holding()));
        chk("model_word_cnt",  32'(word_cnt),  32'(mcnt));
    endtask

    // One clock: drive inputs, advance the model at the edge, sample 1 ns later.
    task automatic step(input logic r, input logic f, input logic sv, input logic sd, input logic ordy);
        rst = r; flush = f; sin_valid = sv; sin_data = sd; out_ready = ordy;
        @(posedge clk);
        model_edge();
        #1;
        chk_model();
    endtask

    task automatic expect_all(input string tag, input logic ev, input logic [7:0] ed,
                              input logic [2:0] ei, input logic er, input logic [1:0] ec);
        chk({tag, ".out_valid"}, 32'(out_valid), 32'(ev));
        chk({tag, ".out_data"},  32'(out_data),  32'(ed));
        chk({tag, ".bit_idx"},   32'(bit_idx),   32'(ei));
        chk({tag, ".sin_ready"}, 32'(sin_ready), 32'(er));
        chk({tag, ".word_cnt"},  32'(word_cnt),  32'(ec));
    endtask

    task automatic send_word(input logic [7:0] w);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b1, w[i], 1'b0);
    endtask

    typedef struct {
        logic       r, f, sv, sd, ordy;
        logic       ev;
        logic [7:0] ed;
        logic [2:0] ei;
        logic       er;
        logic [1:0] ec;
    } vec_t;

    vec_t tbl[13];

    initial begin
        // Basic word 1,0,1,0,0,1,0,1 LSB first, then backpressure and handshake.
        tbl[0]  = '{1'b0,1'b0,1'b1,1'b1,1'b0, 1'b0,8'h01,3'd1,1'b1,2'd0};
        tbl[1]  = '{1'b0,1'b0,1'b1,1'b0,1'b0, 1'b0,8'h01,3'd2,1'b1,2'd0};
        tbl[2]  = '{1'b0,1'b0,1'b1,1'b1,1'b0, 1'b0,8'h05,3'd3,1'b1,2'd0};
        tbl[3]  = '{1'b0,1'b0,1'b1,1'b0,1'b0, 1'b0,8'h05,3'd4,1'b1,2'd0};
        tbl[4]  = '{1'b0,1'b0,1'b1,1'b0,1'b0, 1'b0,8'h05,3'd5,1'b1,2'd0};
        tbl[5]  = '{1'b0,1'b0,1'b1,1'b1,1'b0, 1'b0,8'h25,3'd6,1'b1,2'd0};
        tbl[6]  = '{1'b0,1'b0,1'b1,1'b0,1'b0, 1'b0,8'h25,3'd7,1'b1,2'd0};
        tbl[7]  = '{1'b0,1'b0,1'b1,1'b1,1'b0, 1'b1,8'hA5,3'd0,1'b0,2'd0};
        tbl[8]  = '{1'b0,1'b0,1'b1,1'b1,1'b0, 1'b1,8'hA5,3'd0,1'b0,2'd0};
        tbl[9]  = '{1'b0,1'b0,1'b1,1'b1,1'b0, 1'b1,8'hA5,3'd0,1'b0,2'd0};
        tbl[10] = '{1'b0,1'b0,1'b1,1'b1,1'b0, 1'b1,8'hA5,3'd0,1'b0,2'd0};
        tbl[11] = '{1'b0,1'b0,1'b0,1'b0,1'b1, 1'b0,8'h00,3'd0,1'b1,2'd1};
        tbl[12] = '{1'b0,1'b0,1'b0,1'b0,1'b1, 1'b0,8'h00,3'd0,1'b1,2'd1};

        rst = 1'b1; flush = 1'b0; sin_valid = 1'b0; sin_data = 1'b0; out_ready = 1'b0;
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        expect_all("reset", 1'b0, 8'h00, 3'd0, 1'b1, 2'd0);

        foreach (tbl[i]) begin
            step(tbl[i].r, tbl[i].f, tbl[i].sv, tbl[i].sd, tbl[i].ordy);
            expect_all($sformatf("vec%0d", i), tbl[i].ev, tbl[i].ed, tbl[i].ei, tbl[i].er, tbl[i].ec);
        end

        // Partial visibility, then flush beats a same-cycle accept.
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        expect_all("partial", 1'b0, 8'h07, 3'd3, 1'b1, 2'd1);
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        expect_all("flush", 1'b0, 8'h00, 3'd0, 1'b1, 2'd1);
        send_word(8'hFF);
        expect_all("all_ones", 1'b1, 8'hFF, 3'd0, 1'b0, 2'd1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        expect_all("ack_ff", 1'b0, 8'h00, 3'd0, 1'b1, 2'd2);

        // Bubbles: 0x3C with sin_valid low on alternate cycles.
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
            chk("bubble_no_valid", 32'(out_valid), 32'd0);
            step(1'b0, 1'b0, 1'b1, logic'((8'h3C >> i) & 8'h01), 1'b0);
        end
        expect_all("bubbles", 1'b1, 8'h3C, 3'd0, 1'b0, 2'd2);

        // Flush in HOLD leaves the completed word alone.
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        expect_all("flush_hold", 1'b1, 8'h3C, 3'd0, 1'b0, 2'd2);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        expect_all("ack_3c", 1'b0, 8'h00, 3'd0, 1'b1, 2'd3);
        send_word(8'h5A);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        expect_all("cnt_wrap", 1'b0, 8'h00, 3'd0, 1'b1, 2'd0);
        send_word(8'hC3);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        expect_all("cnt_after_wrap", 1'b0, 8'h00, 3'd0, 1'b1, 2'd1);

        // Reset mid-word, then reset in HOLD racing a handshake.
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        expect_all("five_bits", 1'b0, 8'h1F, 3'd5, 1'b1, 2'd1);
        step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        expect_all("rst_mid", 1'b0, 8'h00, 3'd0, 1'b1, 2'd0);
        send_word(8'h81);
        expect_all("pre_rst_hold", 1'b1, 8'h81, 3'd0, 1'b0, 2'd0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        expect_all("rst_hold", 1'b0, 8'h00, 3'd0, 1'b1, 2'd0);

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            step(logic'($urandom_range(0, 99) == 0),
                 logic'($urandom_range(0, 19) == 0),
                 logic'($urandom_range(0, 2) != 0),
                 logic'($urandom_range(0, 1)),
                 logic'($urandom_range(0, 2) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
